serial_tx_arbiter: RTL and testbench

- Shares one 8N1 serial transmitter between pRequesters byte-stream clients.
- Round-robin arbitration, one-byte buffer per grant, drives the transmitter's data/send/ready handshake.
- Sits between application producers (debug printers, status reporters) and the single transmitter instance on the board.
- Sends the next byte during the previous byte's stop bit, so back-to-back bytes leave no idle gap on the line.

---
 rtl/serial_uart_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/serial_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_uart_pkg.sv
// Shared definitions for the serial transmit/receive slice: FSM encoding
// and global limits used by the arbiter and its priority picker.
package serial_uart_pkg;

  localparam int unsigned cMaxRequesters = 8;
  localparam int unsigned cDataWidth     = 8;

  typedef enum logic [1:0] {
    stIdle   = 2'd0,
    stSend   = 2'd1,
    stSettle = 2'd2
  } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns the first set bit of mask_i found
// scanning upward from pointer_i with wrap-around. Purely combinational.
module rr_priority_picker #(
  parameter  int unsigned pRequesters = 4,
  localparam int unsigned pIndexWidth = $clog2(pRequesters)
) (
  input  logic [pRequesters-1:0] mask_i,
  input  logic [pIndexWidth-1:0] pointer_i,
  output logic [pIndexWidth-1:0] winner_o,
  output logic                   any_o
);

  // Scan from the pointer, keep the first hit.
  always_comb begin
    logic [pIndexWidth-1:0] idx;
    idx      = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int unsigned i = 0; i < pRequesters; i++) begin
      idx = pIndexWidth'((32'(pointer_i) + i) % pRequesters);
      if (!any_o && mask_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter between pRequesters
// byte-stream clients. A byte is latched while the transmitter reports
// ready (idle or stop bit), so consecutive frames leave no idle gap.
// Optional message locking: define SERIAL_TX_ARB_LOCK_EN.
module serial_tx_arbiter
  import serial_uart_pkg::*;
#(
  parameter  int unsigned pRequesters = 4,
  localparam int unsigned pIndexWidth = $clog2(pRequesters)
) (
  input  logic                              iClock,
  input  logic                              iReset,
  input  logic [pRequesters-1:0]            iReqValid,
  input  logic [cDataWidth*pRequesters-1:0] iReqData,
  input  logic [pRequesters-1:0]            iReqLast,
  output logic [pRequesters-1:0]            oReqAck,
  output logic [cDataWidth-1:0]             oTxData,
  output logic                              oTxSend,
  input  logic                              iTxReady,
  output logic [pIndexWidth-1:0]            oGrant,
  output logic                              oBusy
);

  state_t                 state_q, state_d;
  logic [pIndexWidth-1:0] ptr_q, ptr_d;
  logic [pIndexWidth-1:0] grant_q, grant_d;
  logic [cDataWidth-1:0]  data_q, data_d;
  logic [pRequesters-1:0] ack_q, ack_d;
  logic                   send_q, send_d;
  logic [pRequesters-1:0] eligible;
  logic [pIndexWidth-1:0] winner;
  logic                   any_eligible;

`ifdef SERIAL_TX_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked only the last-granted client may win.
  always_comb begin
    eligible = iReqValid;
    if (lock_q) begin
      eligible          = '0;
      eligible[grant_q] = iReqValid[grant_q];
    end
  end
`else
  logic unused_last;
  assign unused_last = ^iReqLast;

  // Per-byte arbitration: every requesting client competes.
  always_comb begin
    eligible = iReqValid;
  end
`endif

  rr_priority_picker #(
    .pRequesters(pRequesters)
  ) u_picker (
    .mask_i   (eligible),
    .pointer_i(ptr_q),
    .winner_o (winner),
    .any_o    (any_eligible)
  );

  // State register.
  always_ff @(posedge iClock) begin
    if (iReset) state_q <= stIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; stSettle covers the transmitter's one-cycle ready lag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      stIdle:   if (iTxReady && any_eligible) state_d = stSend;
      stSend:   state_d = stSettle;
      stSettle: state_d = stIdle;
      default:  state_d = stIdle;
    endcase
  end

  // Output/datapath next values, computed from the next state so that
  // send/ack come out of registers during the stSend cycle.
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    send_d  = 1'b0;
`ifdef SERIAL_TX_ARB_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (state_q == stIdle && state_d == stSend) begin
      data_d        = iReqData[32'(winner)*cDataWidth +: cDataWidth];
      grant_d       = winner;
      ack_d[winner] = 1'b1;
      send_d        = 1'b1;
`ifdef SERIAL_TX_ARB_LOCK_EN
      last_d        = iReqLast[winner];
      if (!iReqLast[winner]) lock_d = 1'b1;
`endif
    end
    if (state_q == stSend) begin
`ifdef SERIAL_TX_ARB_LOCK_EN
      if (last_q) begin
        lock_d = 1'b0;
        ptr_d  = (grant_q == pIndexWidth'(pRequesters-1)) ? '0 : grant_q + 1'b1;
      end
`else
      ptr_d = (grant_q == pIndexWidth'(pRequesters-1)) ? '0 : grant_q + 1'b1;
`endif
    end
  end

  // Output and datapath registers.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      send_q  <= 1'b0;
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
`ifdef SERIAL_TX_ARB_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign oReqAck = ack_q;
  assign oTxData = data_q;
  assign oTxSend = send_q;
  assign oGrant  = grant_q;
  assign oBusy   = (state_q != stIdle) || !iTxReady;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter with a behavioural 8N1 transmitter
// (8 clocks per bit, ready low during start/data bits).
module tb_serial_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ack;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_send, tx_ready, busy;
  logic [1:0]     grant;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.pRequesters(N)) dut (
    .iClock   (clk),
    .iReset   (rst),
    .iReqValid(req_valid),
    .iReqData (req_data),
    .iReqLast (req_last),
    .oReqAck  (req_ack),
    .oTxData  (tx_data),
    .oTxSend  (tx_send),
    .iTxReady (tx_ready),
    .oGrant   (grant),
    .oBusy    (busy)
  );

  // ---------------- transmitter model ----------------
  logic       tx_active, tx_pend, txd;
  logic [3:0] tx_bit;
  logic [2:0] tx_tick;
  logic [7:0] tx_shift, tx_pdata;
  int         frames = 0, chains = 0, active_cycles = 0;

  assign tx_ready = (!tx_active || tx_bit == 4'd9) && !tx_pend;

  always @(posedge clk) begin
    if (rst) begin
      tx_active <= 1'b0; tx_pend <= 1'b0; txd <= 1'b1;
      tx_bit <= '0; tx_tick <= '0;
    end else begin
      if (tx_active) active_cycles <= active_cycles + 1;
      if (!tx_active) begin
        if (tx_send) begin
          tx_active <= 1'b1; tx_bit <= '0; tx_tick <= '0; txd <= 1'b0;
          tx_shift <= tx_data; frames <= frames + 1; chains <= chains + 1;
        end
      end else begin
        if (tx_send) begin tx_pend <= 1'b1; tx_pdata <= tx_data; end
        if (tx_tick == 3'd7) begin
          tx_tick <= '0;
          if (tx_bit == 4'd9) begin
            if (tx_pend || tx_send) begin
              tx_bit <= '0; txd <= 1'b0; tx_pend <= 1'b0;
              tx_shift <= tx_pend ? tx_pdata : tx_data;
              frames <= frames + 1;
            end else begin
              tx_active <= 1'b0; txd <= 1'b1;
            end
          end else begin
            tx_bit <= tx_bit + 4'd1;
            txd <= (tx_bit < 4'd8) ? tx_shift[tx_bit[2:0]] : 1'b1;
          end
        end else begin
          tx_tick <= tx_tick + 3'd1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] d; logic [1:0] g; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, errors = 0;
  logic ready_prev = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_send) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_send: got data 0x%0h grant %0d, expected no send", tx_data, grant);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.d));
          check("grant", 32'(grant), 32'(e.g));
          check("ack_onehot", 32'(req_ack), 32'd1 << e.g);
          check("ready_before_send", 32'(ready_prev), 32'd1);
        end
      end else if (req_ack != '0) begin
        check("ack_without_send", 32'(req_ack), 32'd0);
      end
    end
    ready_prev = tx_ready;
  end

  // ---------------- client scripts ----------------
  typedef struct { logic [7:0] d; logic last; int delay; } item_t;
  item_t script[N][8];
  int    slen[N], sidx[N], swait[N];

  task automatic clear_scripts();
    for (int k = 0; k < N; k++) slen[k] = 0;
  endtask

  task automatic add(input int c, input logic [7:0] d, input logic last, input int delay);
    script[c][slen[c]] = '{d: d, last: last, delay: delay};
    slen[c]++;
  endtask

  task automatic expect_send(input logic [7:0] d, input logic [1:0] g);
    exp_t x;
    x.d = d; x.g = g;
    exp_q.push_back(x);
  endtask

  task automatic run_clients(input int budget);
    int cyc;
    bit done;
    for (int k = 0; k < N; k++) begin
      sidx[k]  = 0;
      swait[k] = (slen[k] > 0) ? script[k][0].delay : 0;
    end
    req_valid = '0; cyc = 0; done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ack[k]) begin
          req_valid[k] = 1'b0;
          sidx[k]++;
          if (sidx[k] < slen[k]) swait[k] = script[k][sidx[k]].delay;
        end
      end
      done = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (sidx[k] < slen[k]) begin
          done = 1'b0;
          if (!req_valid[k]) begin
            if (swait[k] == 0) begin
              req_valid[k]      = 1'b1;
              req_data[8*k +: 8] = script[k][sidx[k]].d;
              req_last[k]       = script[k][sidx[k]].last;
            end else begin
              swait[k]--;
            end
          end
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_clients_timeout: got unfinished scripts after %0d cycles, expected all acked", cyc);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((tx_active || busy) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("drain_idle", 32'(tx_active || busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  int f0, c0, a0;

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_send", 32'(tx_send), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single client 0 sends 0xA5: one 80-tick frame.
    clear_scripts(); add(0, 8'hA5, 1'b1, 0); expect_send(8'hA5, 2'd0);
    f0 = frames; a0 = active_cycles;
    run_clients(3000); drain();
    check("t1_frames", 32'(frames - f0), 32'd1);
    check("t1_ticks", 32'(active_cycles - a0), 32'd80);

    // Single client keeps winning from a nonzero pointer, no gap.
    clear_scripts(); add(0, 8'h5A, 1'b1, 0); add(0, 8'h66, 1'b1, 0);
    expect_send(8'h5A, 2'd0); expect_send(8'h66, 2'd0);
    f0 = frames; c0 = chains;
    run_clients(3000); drain();
    check("t1b_frames", 32'(frames - f0), 32'd2);
    check("t1b_chains", 32'(chains - c0), 32'd1);

    // All clients valid: rotation 0,1,2,3,0 back-to-back.
    do_reset();
    clear_scripts();
    add(0, 8'h10, 1'b1, 0); add(0, 8'h10, 1'b1, 0);
    add(1, 8'h21, 1'b1, 0); add(2, 8'h32, 1'b1, 0); add(3, 8'h43, 1'b1, 0);
    expect_send(8'h10, 2'd0); expect_send(8'h21, 2'd1); expect_send(8'h32, 2'd2);
    expect_send(8'h43, 2'd3); expect_send(8'h10, 2'd0);
    f0 = frames; c0 = chains;
    run_clients(3000); drain();
    check("t2_frames", 32'(frames - f0), 32'd5);
    check("t2_chains", 32'(chains - c0), 32'd1);

    // Client 1 arrives during client 2's data bits; waits for ready.
    do_reset();
    clear_scripts(); add(2, 8'hC2, 1'b1, 0); add(1, 8'hB1, 1'b1, 30);
    expect_send(8'hC2, 2'd2); expect_send(8'hB1, 2'd1);
    f0 = frames; c0 = chains;
    run_clients(3000); drain();
    check("t3_frames", 32'(frames - f0), 32'd2);
    check("t3_chains", 32'(chains - c0), 32'd1);

    // Reset mid-data of 0x3C; pointer returns to client 0.
    clear_scripts(); add(1, 8'h3C, 1'b1, 0); expect_send(8'h3C, 2'd1);
    run_clients(3000);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_send", 32'(tx_send), 32'd0);
    check("midrst_ack", 32'(req_ack), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    clear_scripts(); add(0, 8'h01, 1'b1, 0); add(2, 8'h02, 1'b1, 0);
    expect_send(8'h01, 2'd0); expect_send(8'h02, 2'd2);
    run_clients(3000); drain();

    // Message of three bytes from client 1 with a pause; client 0 competing.
    do_reset();
    clear_scripts();
    add(1, 8'hB1, 1'b0, 0); add(1, 8'hB2, 1'b0, 0); add(1, 8'hB3, 1'b1, 200);
    add(0, 8'hC1, 1'b1, 20); add(0, 8'hC2, 1'b1, 0);
`ifdef SERIAL_TX_ARB_LOCK_EN
    expect_send(8'hB1, 2'd1); expect_send(8'hB2, 2'd1); expect_send(8'hB3, 2'd1);
    expect_send(8'hC1, 2'd0); expect_send(8'hC2, 2'd0);
`else
    expect_send(8'hB1, 2'd1); expect_send(8'hC1, 2'd0); expect_send(8'hB2, 2'd1);
    expect_send(8'hC2, 2'd0); expect_send(8'hB3, 2'd1);
`endif
    run_clients(4000); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
